// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: opcode/funct encodings, fetch FSM states and reset PC.
package cpu_defs;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [5:0] OpcRtype = 6'h00;
  localparam logic [5:0] OpcJ     = 6'h02;
  localparam logic [5:0] OpcJal   = 6'h03;
  localparam logic [5:0] OpcBeq   = 6'h04;
  localparam logic [5:0] OpcBne   = 6'h05;
  localparam logic [5:0] OpcAddi  = 6'h08;
  localparam logic [5:0] OpcXori  = 6'h0E;
  localparam logic [5:0] OpcLw    = 6'h23;
  localparam logic [5:0] OpcSw    = 6'h2B;

  localparam logic [5:0] FunctJr  = 6'h08;
  localparam logic [5:0] FunctAdd = 6'h20;
  localparam logic [5:0] FunctSub = 6'h22;
  localparam logic [5:0] FunctSlt = 6'h2A;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StHold = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and memory.
interface fetch_pc_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_pc_unit_next_pc_logic.sv
// Combinational next-PC selection: jr > jump > taken branch > pc+4.
module next_pc_logic
  import cpu_defs::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] rs_data_i,
  input  logic        jump_i,
  input  logic        jr_i,
  input  logic        beq_i,
  input  logic        bne_i,
  input  logic        alu_zero_i,
  output logic [31:0] next_pc_o
);

  logic [31:0] pc_plus4;
  logic [31:0] imm_sext;
  logic        taken;
  logic        unused_bits;

  assign pc_plus4 = pc_i + 32'd4;
  assign imm_sext = sext16(instr_i[15:0]);
  // beq and bne together is a protocol error and resolves to "not taken".
  assign taken = (beq_i & ~bne_i & alu_zero_i) | (bne_i & ~beq_i & ~alu_zero_i);
  assign unused_bits = ^{instr_i[31:26], rs_data_i[1:0]};

  always_comb begin
    next_pc_o = pc_plus4;
    if (jr_i) begin
      next_pc_o = {rs_data_i[31:2], 2'b00};
    end else if (jump_i) begin
      next_pc_o = {pc_plus4[31:28], instr_i[25:0], 2'b00};
    end else if (taken) begin
      next_pc_o = pc_plus4 + {imm_sext[29:0], 2'b00};
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter, instruction register and fetch handshake FSM of the multicycle CPU.
module fetch_pc_unit
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_start,
  fetch_pc_unit_if.master        imem,
  output logic                   instr_valid,
  output logic                   busy,
  input  logic                   pc_update,
  input  logic                   jump,
  input  logic                   jr,
  input  logic                   beq,
  input  logic                   bne,
  input  logic                   alu_zero,
  input  logic [31:0]            rs_data,
  output logic [31:0]            pc,
  output logic [31:0]            pc_plus4,
  output logic [31:0]            instr,
  output logic [5:0]             opcode,
  output logic [5:0]             funct,
  output logic [4:0]             rs,
  output logic [4:0]             rt,
  output logic [4:0]             rd,
  output logic [31:0]            imm_sext,
  output logic                   protocol_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ir_q, ir_d;
  logic         err_q, err_d;
  logic [31:0]  next_pc;

  next_pc_logic u_next_pc (
    .pc_i       (pc_q),
    .instr_i    (ir_q),
    .rs_data_i  (rs_data),
    .jump_i     (jump),
    .jr_i       (jr),
    .beq_i      (beq),
    .bne_i      (bne),
    .alu_zero_i (alu_zero),
    .next_pc_o  (next_pc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle, StHold: if (fetch_start) state_d = StReq;
      StReq: begin
        if (imem.imem_ack) begin
          ir_d    = imem.imem_rdata;
          state_d = StHold;
        end
      end
      default: state_d = StIdle;
    endcase

    // A PC commit during a fetch would change the address under an open request.
    if (pc_update) begin
      if (state_q == StReq) begin
        err_d = 1'b1;
      end else begin
        pc_d = next_pc;
        if (fetch_start || (beq && bne)) err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      ir_q    <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
    end
  end

  assign imem.imem_req  = (state_q == StReq);
  assign imem.imem_addr = pc_q;
  assign busy           = (state_q == StReq);
  assign instr_valid    = (state_q == StHold);
  assign protocol_err   = err_q;

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;
  assign instr    = ir_q;
  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = sext16(ir_q[15:0]);

endmodule
